// File: rtl/life_calculator.sv
// Registered next-state engine for one Game-of-Life cell with configurable B/S rule masks.
// Optional birth/death statistics counters are built when CALC_STATS_EN is defined.
module life_calculator #(
  parameter logic [8:0] BIRTH_MASK   = 9'b0_0000_1000,
  parameter logic [8:0] SURVIVE_MASK = 9'b0_0000_1100
`ifdef CALC_STATS_EN
  ,
  parameter int unsigned STAT_W      = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       target,
  input  logic       top,
  input  logic       top_right,
  input  logic       right,
  input  logic       bottom_right,
  input  logic       bottom,
  input  logic       bottom_left,
  input  logic       left,
  input  logic       top_left,
  output logic       target_next,
  output logic       out_valid,
  output logic [3:0] nbr_count,
  output logic       changed
`ifdef CALC_STATS_EN
  ,
  output logic [STAT_W-1:0] births,
  output logic [STAT_W-1:0] deaths
`endif
);

  logic [3:0] n;
  logic [8:0] birth_sh;
  logic [8:0] survive_sh;
  logic       next;

  always_comb begin
    n = {3'b000, top} + {3'b000, top_right} + {3'b000, right} + {3'b000, bottom_right}
      + {3'b000, bottom} + {3'b000, bottom_left} + {3'b000, left} + {3'b000, top_left};
  end

  // Shifting the mask keeps the rule lookup in range for any 4-bit count.
  always_comb begin
    birth_sh   = BIRTH_MASK >> n;
    survive_sh = SURVIVE_MASK >> n;
    next       = target ? survive_sh[0] : birth_sh[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_next <= 1'b0;
      out_valid   <= 1'b0;
      nbr_count   <= '0;
      changed     <= 1'b0;
    end else if (in_valid) begin
      target_next <= next;
      out_valid   <= 1'b1;
      nbr_count   <= n;
      changed     <= next ^ target;
    end else begin
      out_valid   <= 1'b0;
    end
  end

`ifdef CALC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      births <= '0;
      deaths <= '0;
    end else if (in_valid) begin
      if (!target && next && (births != '1))
        births <= births + 1'b1;
      if (target && !next && (deaths != '1))
        deaths <= deaths + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_life_calculator.sv
// Self-checking bench for life_calculator: directed Conway cases, exhaustive sweep and random traffic
// compared against a counting model of the B3/S23 rule.
module tb_life_calculator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       target, top, top_right, right, bottom_right, bottom, bottom_left, left, top_left;
  logic       target_next;
  logic       out_valid;
  logic [3:0] nbr_count;
  logic       changed;

  int checks;
  int failures;

  logic       exp_next;
  logic       exp_valid;
  logic [3:0] exp_cnt;
  logic       exp_chg;

`ifdef CALC_STATS_EN
  logic [15:0] births, deaths;
  logic [3:0]  sat_births, sat_deaths;
  logic        sat_next, sat_valid, sat_chg;
  logic [3:0]  sat_cnt;
  int          exp_births, exp_deaths;
  int          exp_sat_births, exp_sat_deaths;
`endif

  life_calculator #(
    .BIRTH_MASK   (9'b0_0000_1000),
    .SURVIVE_MASK (9'b0_0000_1100)
`ifdef CALC_STATS_EN
    ,
    .STAT_W       (16)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .target       (target),
    .top          (top),
    .top_right    (top_right),
    .right        (right),
    .bottom_right (bottom_right),
    .bottom       (bottom),
    .bottom_left  (bottom_left),
    .left         (left),
    .top_left     (top_left),
    .target_next  (target_next),
    .out_valid    (out_valid),
    .nbr_count    (nbr_count),
    .changed      (changed)
`ifdef CALC_STATS_EN
    ,
    .births       (births),
    .deaths       (deaths)
`endif
  );

`ifdef CALC_STATS_EN
  // Narrow-counter copy so saturation is reachable in a few cycles.
  life_calculator #(
    .BIRTH_MASK   (9'b0_0000_1000),
    .SURVIVE_MASK (9'b0_0000_1100),
    .STAT_W       (4)
  ) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .target       (target),
    .top          (top),
    .top_right    (top_right),
    .right        (right),
    .bottom_right (bottom_right),
    .bottom       (bottom),
    .bottom_left  (bottom_left),
    .left         (left),
    .top_left     (top_left),
    .target_next  (sat_next),
    .out_valid    (sat_valid),
    .nbr_count    (sat_cnt),
    .changed      (sat_chg),
    .births       (sat_births),
    .deaths       (sat_deaths)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: count live neighbours, then Conway B3/S23 by plain comparison.
  task automatic model(input logic r, input logic v, input logic [8:0] vec);
    int  n;
    logic t, nx;
    if (r) begin
      exp_next = 0; exp_valid = 0; exp_cnt = 0; exp_chg = 0;
`ifdef CALC_STATS_EN
      exp_births = 0; exp_deaths = 0; exp_sat_births = 0; exp_sat_deaths = 0;
`endif
    end else if (v) begin
      n = 0;
      for (int k = 0; k < 8; k++) n += int'(vec[k]);
      t  = vec[8];
      nx = t ? (n == 2 || n == 3) : (n == 3);
      exp_next  = nx;
      exp_valid = 1;
      exp_cnt   = 4'(n);
      exp_chg   = (nx != t);
`ifdef CALC_STATS_EN
      if (!t && nx) begin
        if (exp_births < 65535) exp_births++;
        if (exp_sat_births < 15) exp_sat_births++;
      end
      if (t && !nx) begin
        if (exp_deaths < 65535) exp_deaths++;
        if (exp_sat_deaths < 15) exp_sat_deaths++;
      end
`endif
    end else begin
      exp_valid = 0;
    end
  endtask

  // Drive on the falling edge, let one rising edge sample, check on the next falling edge.
  task automatic step(input logic r, input logic v, input logic [8:0] vec);
    rst      = r;
    in_valid = v;
    {target, top, top_right, right, bottom_right, bottom, bottom_left, left, top_left} = vec;
    @(posedge clk);
    model(r, v, vec);
    @(negedge clk);
    chk("out_valid",   32'(out_valid),   32'(exp_valid));
    chk("target_next", 32'(target_next), 32'(exp_next));
    chk("nbr_count",   32'(nbr_count),   32'(exp_cnt));
    chk("changed",     32'(changed),     32'(exp_chg));
`ifdef CALC_STATS_EN
    chk("births",     32'(births),     32'(exp_births));
    chk("deaths",     32'(deaths),     32'(exp_deaths));
    chk("sat_births", 32'(sat_births), 32'(exp_sat_births));
    chk("sat_deaths", 32'(sat_deaths), 32'(exp_sat_deaths));
`endif
  endtask

  initial begin
    logic [8:0] vec;
    logic       r, v;
    checks = 0; failures = 0;
    exp_next = 0; exp_valid = 0; exp_cnt = 0; exp_chg = 0;
`ifdef CALC_STATS_EN
    exp_births = 0; exp_deaths = 0; exp_sat_births = 0; exp_sat_deaths = 0;
`endif
    rst = 1'b1; in_valid = 1'b0;
    {target, top, top_right, right, bottom_right, bottom, bottom_left, left, top_left} = '0;

    // Reset state
    step(1'b1, 1'b0, 9'h000);
    step(1'b1, 1'b0, 9'h000);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_next",  32'(target_next), 32'd0);

    // Blinker birth: top, bottom, left live around a dead cell
    step(1'b0, 1'b1, 9'b0_1000_1010);
    chk("blinker_next",  32'(target_next), 32'd1);
    chk("blinker_cnt",   32'(nbr_count),   32'd3);
    chk("blinker_chg",   32'(changed),     32'd1);
    chk("blinker_valid", 32'(out_valid),   32'd1);

    // Survival with 2 and 3 neighbours
    step(1'b0, 1'b1, 9'b1_0010_0010);
    chk("surv2_next", 32'(target_next), 32'd1);
    chk("surv2_chg",  32'(changed),     32'd0);
    step(1'b0, 1'b1, 9'b1_1010_0010);
    chk("surv3_next", 32'(target_next), 32'd1);

    // Under- and overpopulation
    step(1'b0, 1'b1, 9'b1_0000_0010);
    chk("under_next", 32'(target_next), 32'd0);
    step(1'b0, 1'b1, 9'b1_1111_1111);
    chk("over_next", 32'(target_next), 32'd0);
    chk("over_cnt",  32'(nbr_count),   32'd8);

    // Idle: valid drops, data holds
    step(1'b0, 1'b1, 9'b0_1000_1010);
    step(1'b0, 1'b0, 9'b1_0000_0000);
    chk("idle_valid", 32'(out_valid),   32'd0);
    chk("idle_hold",  32'(target_next), 32'd1);

    // Reset with a valid input present discards the sample
    step(1'b1, 1'b1, 9'b0_1000_1010);
    chk("rst_mid_valid", 32'(out_valid),   32'd0);
    chk("rst_mid_next",  32'(target_next), 32'd0);
    chk("rst_mid_cnt",   32'(nbr_count),   32'd0);

`ifdef CALC_STATS_EN
    // Three births, two deaths from a clean reset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 9'b0_1000_1010);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 9'b1_0000_0000);
    chk("stats_births", 32'(births), 32'd3);
    chk("stats_deaths", 32'(deaths), 32'd2);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 9'b0_1000_1010);
    chk("sat_births_hold", 32'(sat_births), 32'hF);
    chk("wide_births",     32'(births),     32'd17);
    step(1'b1, 1'b0, 9'h000);
`endif

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 512; i++) begin
      vec = 9'(i);
      step(1'b0, 1'b1, vec);
    end

    // Random traffic with idle gaps and occasional resets
    for (int i = 0; i < 400; i++) begin
      vec = 9'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 49) == 0);
      step(r, v, vec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
